// File: rtl/femul_arbiter.sv
// Round-robin arbiter that shares one femul multiplier among NREQ requesters.
// One operation in flight; the post-reset drain hides stale femul completions.
module femul_arbiter #(
    parameter int NREQ         = 4,
    parameter int W            = 255,
    parameter int DRAIN_CYCLES = 40,
    parameter int TIMEOUT      = 63
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [W-1:0]        rsp_data,
    output logic                mul_start,
    output logic [W-1:0]        mul_a,
    output logic [W-1:0]        mul_b,
    input  logic                mul_done,
    input  logic [W-1:0]        mul_out,
    output logic                busy,
    output logic                error
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (DRAIN_CYCLES > TIMEOUT) ? DRAIN_CYCLES : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DRAIN_LOAD  = CW'(DRAIN_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_LIM = CW'(TIMEOUT);
    localparam logic [PW-1:0] LAST_IDX    = PW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESPOND
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic              error_q, error_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [W-1:0]      rsp_data_q, rsp_data_d;
    logic [W-1:0]      mul_a_q, mul_a_d;
    logic [W-1:0]      mul_b_q, mul_b_d;

    logic              grant_found;
    logic [PW-1:0]     grant_idx;
    int                scan_idx;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            scan_idx = int'(ptr_q) + off;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(scan_idx);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = (state_q == S_IDLE) && grant_found &&
                                   (grant_idx == PW'(gi));
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        error_d     = error_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        case (state_q)
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_IDLE: begin
                if (grant_found) begin
                    mul_a_d = req_a[int'(grant_idx) * W +: W];
                    mul_b_d = req_b[int'(grant_idx) * W +: W];
                    owner_d = grant_idx;
                    ptr_d   = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (mul_done) begin
                    rsp_data_d           = mul_out;
                    rsp_valid_d          = '0;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = S_RESPOND;
                end else if (cnt_q == TIMEOUT_LIM) begin
                    // Lost operation: drop it and drain in case femul finishes late.
                    error_d = 1'b1;
                    cnt_d   = DRAIN_LOAD;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESPOND: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                cnt_d   = DRAIN_LOAD;
                state_d = S_DRAIN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_DRAIN;
            cnt_q       <= DRAIN_LOAD;
            ptr_q       <= '0;
            owner_q     <= '0;
            error_q     <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            error_q     <= error_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_start = (state_q == S_ISSUE);
    assign busy      = (state_q != S_IDLE);
    assign error     = error_q;

endmodule

// File: doc/femul_arbiter.md
FEMUL_ARBITER -- requirements
Module: femul_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one femul.
REQ-002 Parameter W, default 255: field element width.
REQ-003 Parameter DRAIN_CYCLES, default 40: post-reset guard exceeding femul worst-case start-to-done.
REQ-004 Parameter TIMEOUT, default 63: max BUSY cycles before error.
REQ-005 clock  in  1  single clock; all logic on posedge clock.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 req_valid  in  NREQ  requester i has operands pending.
REQ-008 req_a, req_b  in  NREQ*W  operands; slice i at [i*W +: W].
REQ-009 req_ready  out  NREQ  one-hot grant; operands of i taken this cycle.
REQ-010 rsp_valid  out  NREQ  one-hot; product for requester i on rsp_data.
REQ-011 rsp_ready  in  NREQ  requester i consumes response.
REQ-012 rsp_data  out  W  product a*b mod 2^255-19.
REQ-013 mul_start  out  1  one-cycle start pulse to femul.
REQ-014 mul_a, mul_b  out  W  registered operands to femul.
REQ-015 mul_done, mul_out  in  1, W  femul completion pulse and result.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 error  out  1  sticky timeout flag.

Function
REQ-018 States: DRAIN, IDLE, ISSUE, BUSY, RESPOND; one request in flight at a time.
REQ-019 DRAIN: counter loads DRAIN_CYCLES on reset, decrements each cycle; exit to IDLE when counter reaches 0; mul_done ignored throughout (femul has no reset and may finish a stale operation).
REQ-020 IDLE: if any req_valid, winner = first asserted index scanning ptr, ptr+1, ... mod NREQ; req_ready[winner]=1 combinationally that cycle only; at the edge capture req_a/req_b slice into mul_a/mul_b, owner<=winner, ptr<=(winner+1) mod NREQ, go ISSUE.
REQ-021 req_ready is 0 in every state other than IDLE and 0 for all non-winners.
REQ-022 ISSUE: mul_start=1 for exactly this one cycle; timeout counter cleared; go BUSY.
REQ-023 BUSY: on mul_done, rsp_data<=mul_out, rsp_valid[owner]<=1, go RESPOND; else counter increments.
REQ-024 BUSY with counter reaching TIMEOUT and no mul_done: error<=1, go DRAIN (reload DRAIN_CYCLES); request dropped, no response issued.
REQ-025 mul_done in IDLE, ISSUE or RESPOND is ignored; no state or output change.
REQ-026 RESPOND: hold rsp_valid[owner] and rsp_data stable until rsp_ready[owner]=1; at that edge clear rsp_valid, go IDLE; rsp_ready of other indices ignored.
REQ-027 Earliest regrant is the cycle after response handshake; minimum turnaround = 3 cycles plus femul latency.
REQ-028 req_valid deasserted while in IDLE without grant has no effect; requesters shall not be tracked across cycles.
REQ-029 mul_a/mul_b hold last issued operands until next grant.
REQ-030 Single requester valid continuously: granted every round; ptr fairness guarantees each valid requester granted within NREQ rounds.

Reset
REQ-031 reset overrides all state in any state, including BUSY/RESPOND mid-operation: state DRAIN, counter=DRAIN_CYCLES, ptr=0, owner=0, error=0.
REQ-032 Reset values: req_ready=0, rsp_valid=0, rsp_data=0, mul_start=0, mul_a=0, mul_b=0, busy=1, error=0.
REQ-033 Response pending at reset is discarded; rsp_valid low the cycle after reset.

Verification
REQ-034 Reset, wait DRAIN_CYCLES, req_valid[0]=1, a=3, b=5 -> req_ready[0] one cycle, single mul_start, rsp_valid[0] with rsp_data=15.
REQ-035 All four req_valid held high, operands (i+2, 7) -> grants order 0,1,2,3,0; responses 14,21,28,35 each to correct index.
REQ-036 a=2^255-20 (p-1), b=2 -> rsp_data=2^255-21; rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable, no new req_ready.
REQ-037 Stray mul_done injected in IDLE and during DRAIN -> no rsp_valid, state unchanged.
REQ-038 femul model withholds mul_done -> error=1 after TIMEOUT BUSY cycles, DRAIN entered, no response; next request served normally, error stays 1 until reset.
REQ-039 reset asserted in BUSY, then femul model pulses mul_done during DRAIN -> ignored; first post-drain request returns correct product.
